// File: rtl/if_stage_pkg.sv
// Shared fetch/decoder definitions: next-PC select codes, reset PC, fetch states.
// ERR state only exists when IF_ALIGN_CHECK_EN is defined.
package cpu_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
`ifdef IF_ALIGN_CHECK_EN
        FS_HOLD = 2'd2,
        FS_ERR  = 2'd3
`else
        FS_HOLD = 2'd2
`endif
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC select: sequential, PC-relative branch, region jump, register jump.
module npc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       instr_idx,
    input  logic [1:0]        npc_op,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] npc
);

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jump_tgt;

    assign w_pc_plus4 = pc + ADDR_W'(4);
    // Word offset: sign-extend imm16 and scale by 4.
    assign w_br_off   = {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
    assign w_jump_tgt = {w_pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};

    always_comb begin
        npc = w_pc_plus4;
        case (npc_op)
            NPC_PLUS4:  npc = w_pc_plus4;
            NPC_BRANCH: npc = w_pc_plus4 + w_br_off;
            NPC_JUMP:   npc = w_jump_tgt;
            NPC_JR:     npc = jr_addr;
            default:    npc = w_pc_plus4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// MIPS multi-cycle fetch stage: owns PC, fetches over ready/valid, holds instr until retire.
// Optional IF_ALIGN_CHECK_EN: misaligned next PC raises sticky fetch_err and parks in ERR.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              rstn,
    if_stage_if.master        imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [5:0]        op,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              retire,
    input  logic [1:0]        npc_op,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic              fetch_err
);

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_instr_valid;

    logic              w_req;
    logic              w_load_instr;
    logic              w_retire_take;
    logic [ADDR_W-1:0] w_npc;
    logic [ADDR_W-1:0] w_pc_next;

    npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
        .pc        (r_pc),
        .instr_idx (r_instr[25:0]),
        .npc_op    (npc_op),
        .jr_addr   (jr_addr),
        .npc       (w_npc)
    );

`ifdef IF_ALIGN_CHECK_EN
    logic w_misalign;
    logic r_fetch_err;

    assign w_misalign = |w_npc[1:0];
    assign w_pc_next  = w_npc;
    assign fetch_err  = r_fetch_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_err <= 1'b0;
        end else if (w_retire_take && w_misalign) begin
            r_fetch_err <= 1'b1;
        end
    end
`else
    // Without the checker a bad JR target is silently word-aligned.
    assign w_pc_next = w_npc & ~ADDR_W'(3);
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req         = 1'b0;
        w_load_instr  = 1'b0;
        w_retire_take = 1'b0;
        case (r_state)
            FS_IDLE: w_state_nxt = FS_REQ;
            FS_REQ: begin
                w_req = 1'b1;
                if (imem.imem_ready) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (retire) begin
                    w_retire_take = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
                    w_state_nxt   = w_misalign ? FS_ERR : FS_REQ;
`else
                    w_state_nxt   = FS_REQ;
`endif
                end
            end
`ifdef IF_ALIGN_CHECK_EN
            FS_ERR: w_state_nxt = FS_ERR;
`endif
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc          <= PC_RESET;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_load_instr) begin
                r_instr       <= imem.imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_retire_take) begin
                r_pc          <= w_pc_next;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign op          = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + ADDR_W'(4);

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the multi-cycle MIPS core. Sits directly upstream of the control decoder.
- Owns the PC register and issues requests to instruction memory over a ready/valid handshake.
- Holds the fetched word stable and drives the Op/Funct fields to the decoder.
- Computes the next PC from the retiring instruction's NPCOp, branch immediate, jump target or JR register.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC and instruction-memory address width.

Ports:
- clk  input  1  core clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request, held high until accepted.
- imem_addr  output  ADDR_W  fetch address; equals pc while imem_req is high.
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  held instruction.
- instr_valid  output  1  instr is valid and awaiting retirement.
- op  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- pc  output  ADDR_W  address of the held instruction.
- pc_plus4  output  ADDR_W  pc + 4.
- retire  input  1  one-cycle pulse: the current instruction completes and the PC must advance.
- npc_op  input  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR; sampled with retire.
- jr_addr  input  ADDR_W  rs value used for JR.
- fetch_err  output  1  sticky alignment error; only present when IF_ALIGN_CHECK_EN is defined, otherwise tied 0.

Behaviour:
- Reset (asynchronous, any time, including mid-request):
  - pc=PC_RESET, instr=0, instr_valid=0, imem_req=0, fetch_err=0, state=IDLE.
  - An outstanding request is abandoned; a late imem_ready is ignored.
- States: IDLE, REQ, HOLD, ERR (ERR exists only with IF_ALIGN_CHECK_EN).
  - IDLE: stays exactly one cycle after reset release, then goes to REQ.
  - REQ: imem_req=1, imem_addr=pc. When imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to HOLD. Minimum latency is 1 cycle from REQ entry to instr_valid.
  - HOLD: instr, pc, op and funct stay stable. When retire=1: pc<=npc, instr_valid<=0, go to REQ next cycle.
- retire is ignored outside HOLD (no PC change, no error).
- imem_ready is ignored outside REQ.
- Next-PC arithmetic, mod 2^32; the immediate and target are taken from the held instr:
  - PLUS4: pc+4.
  - BRANCH: pc+4 + (sign-extended instr[15:0] << 2).
  - JUMP: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - JR: jr_addr.
- Wrap-around: pc=32'hFFFF_FFFC with PLUS4 gives 0. No trap.
- pc_plus4 and op/funct are combinational from the pc and instr registers.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined: on retire, if npc[1:0]!=0, then fetch_err<=1 (sticky until reset), pc<=npc unmodified, and the state goes to ERR. In ERR, imem_req=0 and instr_valid=0, and the block stays there until reset.
- Undefined: npc[1:0] is forced to 00, fetching continues normally, and fetch_err is a constant 0.

Decomposition:
- Shared package (cpu_pkg):
  - NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JR 2-bit constants, shared with the control decoder.
  - PC_RESET default.
  - Fetch state enum.
- Sub-module npc_calc: combinational next-PC mux. Inputs pc, instr[25:0], npc_op, jr_addr; output npc.
- The FSM and registers stay in if_stage.

Test Plan:
- Reset release, imem_ready=1 every cycle:
  - imem_req rises 1 cycle after IDLE with imem_addr=0x3000.
  - instr_valid=1 the next cycle, with op/funct matching imem_rdata=0x014B4820 (op=0, funct=0x20).
- HOLD, retire, npc_op=PLUS4 at pc=0x3000: next request address is 0x3004.
- Branch at pc=0x3008, instr imm16=0xFFFE, npc_op=BRANCH: npc = 0x300C - 8 = 0x3004.
- Jump at pc=0x3010, instr=0x08000C10, npc_op=JUMP: npc=0x00003040.
- JR with jr_addr=0x3402, retire in HOLD:
  - IF_ALIGN_CHECK_EN defined: fetch_err=1, imem_req stays 0.
  - Undefined: next address is 0x3400.
- Assert rstn=0 while in REQ with imem_ready stalled low for 3 cycles:
  - Outputs return to reset values immediately; pc=0x3000.
  - After release, the fetch restarts from 0x3000.
  - Pulse retire during REQ: pc is unchanged.
